// File: rtl/sphere3hopf_point_fifo.sv
// Point FIFO between the sphere3hopf generator and a valid/ready consumer.
// Throttles the generator with a registered pop_enable that keeps SKID entries free.
module sphere3hopf_point_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned SKID  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       run,
  input  logic                       flush,
  input  logic                       gen_valid,
  input  logic [WIDTH-1:0]           gen_x,
  input  logic [WIDTH-1:0]           gen_y,
  input  logic [WIDTH-1:0]           gen_z,
  input  logic [WIDTH-1:0]           gen_w,
  output logic                       gen_pop_enable,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_x,
  output logic [WIDTH-1:0]           out_y,
  output logic [WIDTH-1:0]           out_z,
  output logic [WIDTH-1:0]           out_w,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic [31:0]                points_out
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] FullLevel  = LW'(DEPTH);
  localparam logic [LW-1:0] ThrottleAt = LW'(DEPTH - SKID);

  logic [4*WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;
  logic [31:0]   points_q, points_d;
  logic          pop_en_q, pop_en_d;

  logic full, do_pop, do_push, do_drop;

  always_comb begin
    full    = (level_q == FullLevel);
    // Flush wins over any same-cycle push or pop.
    do_pop  = (level_q != '0) && out_ready && !flush;
    do_push = gen_valid && !flush && (!full || do_pop);
    do_drop = gen_valid && !flush && full && !do_pop;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    points_d   = points_q;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        points_d = points_q + 32'd1;
      end
      unique case ({do_push, do_pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
      if (do_drop) overflow_d = 1'b1;
    end
    // Free space after this cycle must exceed SKID to keep requesting.
    pop_en_d = run && (level_d < ThrottleAt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      points_q   <= '0;
      pop_en_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      points_q   <= points_d;
      pop_en_q   <= pop_en_d;
    end
  end

  // Storage has no reset; empty-state outputs are masked instead.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= {gen_x, gen_y, gen_z, gen_w};
  end

  always_comb begin
    out_valid = (level_q != '0);
    if (out_valid) {out_x, out_y, out_z, out_w} = mem[rd_ptr_q];
    else           {out_x, out_y, out_z, out_w} = '0;
  end

  assign gen_pop_enable = pop_en_q;
  assign level          = level_q;
  assign overflow       = overflow_q;
  assign points_out     = points_q;

endmodule
